// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame defaults
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_PARITY_ENABLED = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input.
// Resets to 1 so an idle-high line does not look like an edge.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: mid-bit sampling, start glitch rejection,
// even-parity and stop-bit checking with sticky error detail.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PARITY_ENABLED   = DEF_PARITY_ENABLED,
   parameter int CLOCKS_PER_BIT   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_in,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        data_is_valid,
   output logic                        rx_error,
   output logic                        parity_error,
   output logic                        framing_error,
   output logic                        o_rx_busy
);

   localparam int CW   = $clog2(CLOCKS_PER_BIT);
   localparam int IW   = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
   localparam int HALF = CLOCKS_PER_BIT / 2;

   rx_state_t                   state, state_nxt;
   logic [CW-1:0]               cnt, cnt_nxt;
   logic [IW-1:0]               idx, idx_nxt;
   logic [INPUT_DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [INPUT_DATA_WIDTH-1:0] data_nxt;
   logic                        par_bit, par_nxt;
   logic                        dv_nxt, err_nxt, pe_nxt, fe_nxt;
   logic                        rx_s, rx_d;
   logic                        last, par_ok;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (serial_in),
      .q     (rx_s)
   );

   assign last      = (cnt == CW'(CLOCKS_PER_BIT - 1));
   assign par_ok    = (PARITY_ENABLED == 0) ||
                      (even_parity(32'(shreg)) == par_bit);
   assign o_rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         par_bit       <= 1'b0;
         rx_d          <= 1'b1;
         received_data <= '0;
         data_is_valid <= 1'b0;
         rx_error      <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         idx           <= idx_nxt;
         shreg         <= shreg_nxt;
         par_bit       <= par_nxt;
         rx_d          <= rx_s;
         received_data <= data_nxt;
         data_is_valid <= dv_nxt;
         rx_error      <= err_nxt;
         parity_error  <= pe_nxt;
         framing_error <= fe_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      data_nxt  = received_data;
      dv_nxt    = 1'b0;
      err_nxt   = 1'b0;
      pe_nxt    = parity_error;
      fe_nxt    = framing_error;
      unique case (state)
         IDLE: begin
            if (!rx_s && rx_d) begin
               state_nxt = START;
               cnt_nxt   = '0;
               pe_nxt    = 1'b0;
               fe_nxt    = 1'b0;
            end
         end
         START: begin
            if (cnt == CW'(HALF - 1)) begin
               cnt_nxt = '0;
               idx_nxt = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (last) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rx_s;
               if (idx == IW'(INPUT_DATA_WIDTH - 1)) begin
                  state_nxt = (PARITY_ENABLED != 0) ? PARITY : STOP;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (last) begin
               cnt_nxt   = '0;
               par_nxt   = rx_s;
               state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (last) begin
               cnt_nxt = '0;
               if (rx_s && par_ok) begin
                  data_nxt  = shreg;
                  dv_nxt    = 1'b1;
                  state_nxt = IDLE;
               end else if (rx_s) begin
                  err_nxt   = 1'b1;
                  pe_nxt    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  // break or lost stop bit: wait for the line to go idle
                  err_nxt   = 1'b1;
                  fe_nxt    = 1'b1;
                  pe_nxt    = !par_ok;
                  state_nxt = WAIT_IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomized and directed frames checked against a frame-level
// reference model and an event scoreboard.
module tb_uart_rx_sampler;

   localparam int W   = 8;
   localparam int CPB = 16;
   localparam int LAT = 2 + CPB / 2 + (W + 1 + 1) * CPB;

   typedef struct {
      int         cyc;
      logic       bad;
      logic [7:0] data;
      logic       pe;
      logic       fe;
   } ev_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         serial_in = 1'b1;
   logic [W-1:0] received_data;
   logic         data_is_valid;
   logic         rx_error;
   logic         parity_error;
   logic         framing_error;
   logic         o_rx_busy;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   viol = 0;
   logic prev_pulse = 1'b0;
   logic [7:0] last_good = 8'h00;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   uart_rx_sampler #(
      .INPUT_DATA_WIDTH (W),
      .PARITY_ENABLED   (1),
      .CLOCKS_PER_BIT   (CPB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .serial_in     (serial_in),
      .received_data (received_data),
      .data_is_valid (data_is_valid),
      .rx_error      (rx_error),
      .parity_error  (parity_error),
      .framing_error (framing_error),
      .o_rx_busy     (o_rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         if (data_is_valid || rx_error) begin
            obs_q.push_back('{cyc, rx_error, received_data,
                              parity_error, framing_error});
            if (prev_pulse) viol++;
         end
         if (data_is_valid && rx_error) viol++;
      end
      prev_pulse = data_is_valid || rx_error;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      serial_in = b;
      tick(CPB);
   endtask

   // Model: the frame outcome follows from the bits on the wire alone.
   task automatic send_frame(input logic [7:0] d, input logic flip,
                             input logic stop);
      int   t0;
      logic p;
      logic par_bad;
      logic ok;
      t0      = cyc;
      p       = (^d) ^ flip;
      par_bad = (^d) ^ p;
      ok      = stop && !par_bad;
      drive_bit(1'b0);
      for (int i = 0; i < W; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(stop);
      exp_q.push_back('{t0 + 1 + LAT, !ok, ok ? d : last_good,
                        !ok && par_bad, !stop});
      if (ok) last_good = d;
   endtask

   task automatic flush(input string tag);
      ev_t e;
      ev_t o;
      tick(24);
      chk({tag, "_n_events"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, "_cyc"}, o.cyc, e.cyc);
         chk({tag, "_bad"}, o.bad, e.bad);
         chk({tag, "_data"}, o.data, e.data);
         chk({tag, "_pe"}, o.pe, e.pe);
         chk({tag, "_fe"}, o.fe, e.fe);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dv"}, data_is_valid, 0);
      chk({tag, "_err"}, rx_error, 0);
      chk({tag, "_pe"}, parity_error, 0);
      chk({tag, "_fe"}, framing_error, 0);
      chk({tag, "_busy"}, o_rx_busy, 0);
      chk({tag, "_data"}, received_data, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       flip;
      logic       stop;
      int         t;

      tick(3);
      chk_all_zero("reset");
      reset = 1'b1;
      tick(5);

      send_frame(8'hA5, 1'b0, 1'b1);
      tick(4);
      flush("a5");
      chk("a5_rdata", received_data, 8'hA5);

      send_frame(8'h3C, 1'b1, 1'b1);
      tick(4);
      flush("3c_par");
      chk("3c_pe_sticky", parity_error, 1);
      chk("3c_fe", framing_error, 0);

      send_frame(8'h00, 1'b0, 1'b0);
      serial_in = 1'b0;
      tick(40 * CPB);
      chk("break_busy_low", o_rx_busy, 1);
      serial_in = 1'b1;
      tick(1);
      chk("break_busy_edge", o_rx_busy, 1);
      tick(4);
      chk("break_busy_idle", o_rx_busy, 0);
      chk("break_fe_sticky", framing_error, 1);
      flush("break");

      t = cyc;
      serial_in = 1'b0;
      tick(5);
      serial_in = 1'b1;
      chk("glitch_busy", o_rx_busy, 1);
      tick(10);
      chk("glitch_idle", o_rx_busy, 0);
      flush("glitch");

      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      serial_in = 1'b1;
      tick(4);
      flush("b2b");

      drive_bit(1'b0);
      drive_bit(1'b1);
      for (int i = 0; i < 3; i++) drive_bit(1'b0);
      serial_in = 1'b0;
      tick(8);
      reset = 1'b0;
      serial_in = 1'b1;
      tick(3);
      chk_all_zero("midrst");
      tick(2);
      reset = 1'b1;
      last_good = 8'h00;
      tick(3 * CPB);
      flush("aborted");
      send_frame(8'h7E, 1'b0, 1'b1);
      tick(4);
      flush("7e");
      chk("7e_rdata", received_data, 8'h7E);

      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, flip, stop);
         serial_in = 1'b1;
         tick(stop ? $urandom_range(0, 12) : $urandom_range(4, 20));
      end
      tick(4);
      flush("rand");

      chk("protocol_viol", viol, 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
